// File: rtl/ahb_clac_pkg.sv
// ahb_clac_pkg: AHB-Lite encodings, default calculator register map and master FSM states.
package ahb_clac_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [7:0] DEF_ADDR_OPA  = 8'h00;
    localparam logic [7:0] DEF_ADDR_OPB  = 8'h04;
    localparam logic [7:0] DEF_ADDR_MODE = 8'h08;
    localparam logic [7:0] DEF_ADDR_CTRL = 8'h0C;
    localparam logic [7:0] DEF_ADDR_RES  = 8'h10;
    typedef enum logic [1:0] {IDLE, XFER, LAST, RESP} state_t;
endpackage

// File: rtl/ahb_clac_master_if.sv
// ahb_clac_master_if: command/response handshake plus the AHB-Lite master bus.
interface ahb_clac_master_if;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_opa, cmd_opb;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_result;
    logic        hsel, hwrite;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans;
    logic [7:0]  haddr;
    logic [31:0] hwdata;
    logic        hready_resp;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    modport master (
        input  cmd_valid, cmd_mode, cmd_opa, cmd_opb, rsp_ready, hready_resp, hresp, hrdata,
        output cmd_ready, rsp_valid, rsp_result, rsp_error, hsel, hwrite, hsize, htrans, hburst, haddr, hwdata
    );
    modport slave (
        output cmd_valid, cmd_mode, cmd_opa, cmd_opb, rsp_ready, hready_resp, hresp, hrdata,
        input  cmd_ready, rsp_valid, rsp_result, rsp_error, hsel, hwrite, hsize, htrans, hburst, haddr, hwdata
    );
endinterface

// File: rtl/ahb_clac_master.sv
// ahb_clac_master: per command, writes OPA/OPB/MODE/CTRL to an AHB-Lite calculator slave,
// reads RES back and returns the result, or flags an ERROR response and abandons the sequence.
module ahb_clac_master
    import ahb_clac_pkg::*;
#(
    parameter logic [7:0] ADDR_OPA  = DEF_ADDR_OPA,
    parameter logic [7:0] ADDR_OPB  = DEF_ADDR_OPB,
    parameter logic [7:0] ADDR_MODE = DEF_ADDR_MODE,
    parameter logic [7:0] ADDR_CTRL = DEF_ADDR_CTRL,
    parameter logic [7:0] ADDR_RES  = DEF_ADDR_RES
) (
    input logic               hclk,
    input logic               hresetn,
    ahb_clac_master_if.master bus
);
    state_t      state, state_n;
    logic [2:0]  idx;
    logic [15:0] opa_q, opb_q;
    logic [1:0]  mode_q, htrans_q;
    logic        hsel_q, hwrite_q, data_phase, err, accept, launch, advance, finish;

    function automatic logic [7:0] addr_of(input logic [2:0] i);
        return i == 3'd0 ? ADDR_OPA : i == 3'd1 ? ADDR_OPB : i == 3'd2 ? ADDR_MODE :
               i == 3'd3 ? ADDR_CTRL : ADDR_RES;
    endfunction

    function automatic logic [31:0] wdata_of(input logic [2:0] i);
        return i == 3'd0 ? {16'h0, opa_q} : i == 3'd1 ? {16'h0, opb_q} :
               i == 3'd2 ? {30'h0, mode_q} : 32'h1;
    endfunction

    // idx names the transfer in its address phase, so idx-1 is in its data phase
    assign data_phase = (state == XFER && idx != 3'd0) || state == LAST;
    assign err        = data_phase && bus.hresp == HRESP_ERROR;
    assign accept     = state == IDLE && bus.cmd_valid;
    assign launch     = state == XFER && htrans_q == HTRANS_IDLE && bus.hready_resp && !err;
    assign advance    = state == XFER && htrans_q == HTRANS_NONSEQ && bus.hready_resp && !err;
    assign finish     = data_phase && bus.hready_resp && (err || state == LAST);

    // an ERROR data phase kills the pending address phase combinationally
    assign bus.htrans    = err ? HTRANS_IDLE : htrans_q;
    assign bus.hsel      = hsel_q && !err;
    assign bus.hwrite    = hwrite_q && !err;
    assign bus.hsize     = HSIZE_WORD;
    assign bus.hburst    = HBURST_SINGLE;
    assign bus.cmd_ready = state == IDLE;
    assign bus.rsp_valid = state == RESP;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.cmd_valid ? XFER : IDLE;
            XFER:    state_n = finish ? RESP : (advance && idx == 3'd4) ? LAST : XFER;
            LAST:    state_n = finish ? RESP : LAST;
            RESP:    state_n = bus.rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge hclk) state <= !hresetn ? IDLE : state_n;

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            idx            <= 3'd0;
            opa_q          <= 16'h0;
            opb_q          <= 16'h0;
            mode_q         <= 2'b00;
            htrans_q       <= HTRANS_IDLE;
            hsel_q         <= 1'b0;
            hwrite_q       <= 1'b0;
            bus.haddr      <= 8'h0;
            bus.hwdata     <= 32'h0;
            bus.rsp_result <= 32'h0;
            bus.rsp_error  <= 1'b0;
        end else begin
            if (accept) begin
                idx    <= 3'd0;
                opa_q  <= bus.cmd_opa;
                opb_q  <= bus.cmd_opb;
                mode_q <= bus.cmd_mode;
            end
            if (launch) begin
                htrans_q  <= HTRANS_NONSEQ;
                hsel_q    <= 1'b1;
                hwrite_q  <= 1'b1;
                bus.haddr <= addr_of(3'd0);
            end
            if (advance) begin
                idx       <= idx == 3'd4 ? idx : idx + 3'd1;
                bus.haddr <= addr_of(idx + 3'd1);
                htrans_q  <= idx == 3'd4 ? HTRANS_IDLE : HTRANS_NONSEQ;
                hsel_q    <= idx != 3'd4;
                hwrite_q  <= idx < 3'd3;
                if (idx != 3'd4) bus.hwdata <= wdata_of(idx);
            end
            if (err) begin
                htrans_q <= HTRANS_IDLE;
                hsel_q   <= 1'b0;
                hwrite_q <= 1'b0;
            end
            if (finish) begin
                bus.rsp_result <= err ? 32'h0 : bus.hrdata;
                bus.rsp_error  <= err;
            end
        end
    end
endmodule

// File: tb/tb_ahb_clac_master.sv
// tb_ahb_clac_master: vector table of calc commands against an AHB-Lite slave model,
// plus hand-written backpressure and mid-sequence reset sequences.
module tb_ahb_clac_master;
    import ahb_clac_pkg::*;

    logic hclk = 1'b0;
    logic hresetn = 1'b0;
    ahb_clac_master_if bus();
    ahb_clac_master dut (.hclk(hclk), .hresetn(hresetn), .bus(bus));
    always #5 hclk = ~hclk;

    typedef struct {
        logic [15:0] opa, opb;
        logic [1:0]  mode;
        logic [31:0] rdata;
        logic [7:0]  wait_addr;
        int          waits;
        logic [7:0]  err_addr;
        int          lat;
        logic        err;
        logic [31:0] res;
        int          ntrans;
        bit          busy;
    } vec_t;

    int checks = 0, failures = 0;
    bit          dp_valid, dp_write, prev_wait;
    logic [7:0]  dp_addr, s_wait_addr, s_err_addr, p_haddr;
    int          wait_left, err_cnt, s_waits;
    logic [31:0] s_rdata, p_hwdata;
    logic [1:0]  p_htrans;
    logic        p_hwrite, p_hsel;
    logic [7:0]  log_q[$];
    logic [31:0] mem[8];
    logic [7:0]  exp_addr[5] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};
    vec_t        vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_error", bus.rsp_error, 0);
        check("rst_rsp_result", bus.rsp_result, 0);
        check("rst_hsel", bus.hsel, 0);
        check("rst_hwrite", bus.hwrite, 0);
        check("rst_htrans", bus.htrans, 2'b00);
        check("rst_hsize", bus.hsize, 3'b010);
        check("rst_hburst", bus.hburst, 3'b000);
        check("rst_haddr", bus.haddr, 0);
        check("rst_hwdata", bus.hwdata, 0);
    endtask

    task automatic reset_slave();
        dp_valid = 0;
        dp_write = 0;
        dp_addr = 8'hFF;
        wait_left = 0;
        err_cnt = 0;
        prev_wait = 0;
        log_q.delete();
        for (int i = 0; i < 8; i++) mem[i] = 32'h5555_5555;
    endtask

    // one bus cycle: slave response, output checks, then the clock edge; starts and ends at negedge
    task automatic cycle();
        bus.hready_resp = 1'b1;
        bus.hresp = HRESP_OKAY;
        bus.hrdata = 32'hBAD0_BAD0;
        if (dp_valid) begin
            if (dp_addr == s_err_addr) begin
                bus.hready_resp = err_cnt != 0;
                bus.hresp = HRESP_ERROR;
            end else if (wait_left > 0) bus.hready_resp = 1'b0;
            else if (!dp_write) bus.hrdata = s_rdata;
        end
        #1;
        if (dp_valid && dp_addr == s_err_addr && err_cnt == 0) check("err_htrans_idle", bus.htrans, HTRANS_IDLE);
        if (bus.htrans == HTRANS_NONSEQ) begin
            check("nonseq_hsel", bus.hsel, 1);
            check("nonseq_hsize", bus.hsize, HSIZE_WORD);
            check("nonseq_hburst", bus.hburst, HBURST_SINGLE);
        end else begin
            check("idle_htrans", bus.htrans, HTRANS_IDLE);
            check("idle_hsel", bus.hsel, 0);
            check("idle_hwrite", bus.hwrite, 0);
        end
        if (prev_wait) begin
            check("wait_haddr", bus.haddr, p_haddr);
            check("wait_htrans", bus.htrans, p_htrans);
            check("wait_hwrite", bus.hwrite, p_hwrite);
            check("wait_hsel", bus.hsel, p_hsel);
            check("wait_hwdata", bus.hwdata, p_hwdata);
        end
        prev_wait = dp_valid && !bus.hready_resp && dp_addr != s_err_addr;
        p_haddr = bus.haddr;
        p_htrans = bus.htrans;
        p_hwrite = bus.hwrite;
        p_hsel = bus.hsel;
        p_hwdata = bus.hwdata;
        if (!bus.hready_resp) begin
            if (dp_addr == s_err_addr) err_cnt++;
            else wait_left--;
        end else begin
            if (dp_valid && dp_write && dp_addr != s_err_addr) mem[dp_addr[4:2]] = bus.hwdata;
            dp_valid = bus.htrans == HTRANS_NONSEQ;
            dp_addr = bus.haddr;
            dp_write = bus.hwrite;
            wait_left = bus.haddr == s_wait_addr ? s_waits : 0;
            err_cnt = 0;
            if (dp_valid) log_q.push_back(bus.haddr);
        end
        @(posedge hclk);
        @(negedge hclk);
    endtask

    task automatic load_cmd(input vec_t v);
        bus.cmd_opa = v.opa;
        bus.cmd_opb = v.opb;
        bus.cmd_mode = v.mode;
        s_rdata = v.rdata;
        s_wait_addr = v.wait_addr;
        s_waits = v.waits;
        s_err_addr = v.err_addr;
    endtask

    task automatic run_cmd(input vec_t v, input int hold, input bit chain, input vec_t nxt);
        int k;
        reset_slave();
        load_cmd(v);
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = v.busy;
        #1 check("cmd_ready_idle", bus.cmd_ready, 1);
        cycle();
        bus.cmd_valid = v.busy;
        bus.cmd_opa = ~v.opa;
        bus.cmd_opb = ~v.opb;
        bus.cmd_mode = ~v.mode;
        k = 0;
        while (!bus.rsp_valid && k < 40) begin
            cycle();
            k++;
        end
        check("latency", k, v.lat);
        bus.cmd_valid = chain;
        if (chain) begin
            bus.cmd_opa = nxt.opa;
            bus.cmd_opb = nxt.opb;
            bus.cmd_mode = nxt.mode;
        end
        check("rsp_result", bus.rsp_result, v.res);
        check("rsp_error", bus.rsp_error, v.err);
        for (int i = 0; i < hold; i++) begin
            bus.rsp_ready = 1'b0;
            cycle();
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_result", bus.rsp_result, v.res);
            check("hold_error", bus.rsp_error, v.err);
            check("hold_cmd_ready", bus.cmd_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        cycle();
        bus.rsp_ready = 1'b0;
        check("rsp_done", bus.rsp_valid, 0);
        check("cmd_ready_back", bus.cmd_ready, 1);
        check("ntrans", log_q.size(), v.ntrans);
        for (int i = 0; i < log_q.size() && i < 5; i++) check("addr_order", log_q[i], exp_addr[i]);
        if (!v.err) begin
            check("mem_opa", mem[0], {16'h0, v.opa});
            check("mem_opb", mem[1], {16'h0, v.opb});
            check("mem_mode", mem[2], {30'h0, v.mode});
            check("mem_ctrl", mem[3], 32'h1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int k;
        //       opa       opb       mode   rdata          wait   n  err    lat err res            nt busy
        vt[0] = '{16'h0003, 16'h0004, 2'b00, 32'h0000_0007, 8'hFF, 0, 8'hFF, 7,  0, 32'h0000_0007, 5, 0};
        vt[1] = '{16'h1234, 16'hABCD, 2'b11, 32'hA5A5_0001, 8'h08, 2, 8'hFF, 9,  0, 32'hA5A5_0001, 5, 0};
        vt[2] = '{16'h0011, 16'h0022, 2'b01, 32'h0000_0099, 8'hFF, 0, 8'h04, 5,  1, 32'h0,         2, 0};
        vt[3] = '{16'hFFFF, 16'hFFFF, 2'b10, 32'hFFFF_FFFF, 8'h10, 3, 8'hFF, 10, 0, 32'hFFFF_FFFF, 5, 1};
        vt[4] = '{16'h8000, 16'h0001, 2'b01, 32'h1234_5678, 8'hFF, 0, 8'h10, 8,  1, 32'h0,         5, 0};
        vt[5] = '{16'h00AA, 16'h0055, 2'b10, 32'h0000_00FF, 8'hFF, 0, 8'h00, 4,  1, 32'h0,         1, 1};
        vt[6] = '{16'h7FFF, 16'h0002, 2'b11, 32'hCAFE_F00D, 8'h00, 1, 8'hFF, 8,  0, 32'hCAFE_F00D, 5, 0};
        bus.cmd_valid = 1'b0;
        bus.cmd_opa = 16'h0;
        bus.cmd_opb = 16'h0;
        bus.cmd_mode = 2'b00;
        bus.rsp_ready = 1'b0;
        bus.hready_resp = 1'b1;
        bus.hresp = HRESP_OKAY;
        bus.hrdata = 32'h0;
        s_err_addr = 8'hFF;
        s_wait_addr = 8'hFF;
        s_waits = 0;
        s_rdata = 32'h0;
        reset_slave();
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
        #1 check_reset();

        for (int i = 0; i < 7; i++) run_cmd(vt[i], 0, 1'b0, vt[i]);

        // response backpressure with a new command waiting
        run_cmd(vt[0], 5, 1'b1, vt[1]);
        run_cmd(vt[1], 0, 1'b0, vt[1]);

        // reset during the CTRL address phase
        reset_slave();
        load_cmd(vt[0]);
        bus.cmd_valid = 1'b1;
        cycle();
        bus.cmd_valid = 1'b0;
        k = 0;
        while (!(bus.htrans == HTRANS_NONSEQ && bus.haddr == 8'h0C) && k < 20) begin
            cycle();
            k++;
        end
        check("reach_ctrl", k < 20, 1);
        hresetn = 1'b0;
        cycle();
        hresetn = 1'b1;
        #1 check_reset();
        reset_slave();
        repeat (3) begin
            cycle();
            check("no_rsp_after_reset", bus.rsp_valid, 0);
        end
        run_cmd(vt[0], 0, 1'b0, vt[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb_clac_master.md
AHB_CLAC_MASTER -- requirements
Module: ahb_clac_master

Interface
REQ-001 SHALL have parameter ADDR_OPA, default 8'h00, offset of the operand-A register.
REQ-002 SHALL have parameter ADDR_OPB, default 8'h04, offset of the operand-B register.
REQ-003 SHALL have parameter ADDR_MODE, default 8'h08, offset of the calc-mode register.
REQ-004 SHALL have parameter ADDR_CTRL, default 8'h0C, offset of the start/ctrl register.
REQ-005 SHALL have parameter ADDR_RES, default 8'h10, offset of the result register.
REQ-006 SHALL have ports, one per line:
- hclk  in  1  single clock, rising edge.
- hresetn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_mode  in  2  calc mode.
- cmd_opa  in  16  operand A.
- cmd_opb  in  16  operand B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed when high with rsp_valid.
- rsp_result  out  32  read-back result.
- rsp_error  out  1  a transfer ended with ERROR.
- hsel  out  1  slave select.
- hwrite  out  1  write/read.
- hsize  out  3  transfer size.
- htrans  out  2  transfer type.
- hburst  out  3  burst type.
- haddr  out  8  address.
- hwdata  out  32  write data.
- hready_resp  in  1  slave ready, also the bus hready.
- hresp  in  2  slave response.
- hrdata  in  32  read data.

Function
REQ-007 SHALL implement the states IDLE, XFER, LAST, RESP.
REQ-008 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready it SHALL capture the mode and both operands and enter XFER.
REQ-009 SHALL issue, in XFER, five single AHB-Lite transfers in order:
- write OPA, data {16'h0, opa};
- write OPB, data {16'h0, opb};
- write MODE, data {30'h0, mode};
- write CTRL, data 32'h1;
- read RES.
REQ-010 SHALL drive each transfer with htrans=NONSEQ (2'b10), hsize=3'b010, hburst=3'b000 and hsel=1 during its address phase.
REQ-011 SHALL drive htrans=IDLE (2'b00), hsel=0 and hwrite=0 whenever no address phase is active.
REQ-012 SHALL pipeline the transfers: the address phase of transfer n+1 coincides with the data phase of transfer n.
REQ-013 SHALL drive hwdata during the data phase of a write, from the value registered at its address phase.
REQ-014 SHALL advance address/control and hwdata only on a clock edge where hready_resp=1; during wait states all outputs SHALL be held stable.
REQ-015 SHALL enter LAST once the RES address phase is accepted, and SHALL capture hrdata when the read data phase completes with hready_resp=1 and hresp=2'b00.
REQ-016 SHALL then enter RESP with rsp_valid=1 and rsp_error=0.
REQ-017 SHALL give a zero-wait latency of 7 cycles: accept at edge 0, address phases on cycles 1-5, read data phase on cycle 6, rsp_valid high from edge 7.
REQ-018 SHALL hold rsp_valid, rsp_result and rsp_error stable until rsp_ready=1, then return to IDLE on the next edge; rsp_ready is ignored outside RESP.
REQ-019 SHALL respond to hresp=ERROR (2'b01) with hready_resp=0 (first error cycle) by driving htrans=IDLE in the same cycle, cancelling all remaining transfers.
REQ-020 SHALL, on the following edge with hready_resp=1, go to RESP with rsp_error=1 and rsp_result=32'h0.
REQ-021 SHALL ignore hrdata on write data phases and ignore cmd_valid outside IDLE.

Reset
REQ-022 SHALL, on hresetn low at a clock edge, set: state IDLE, cmd_ready=1 from the next cycle, rsp_valid=0, rsp_error=0, rsp_result=0, hsel=0, hwrite=0, htrans=2'b00, hsize=3'b010, hburst=3'b000, haddr=0, hwdata=0.
REQ-023 SHALL on reset mid-sequence abandon the sequence without completing outstanding data phases and produce no response.

Structure
REQ-024 SHALL take from shared package ahb_clac_pkg: HTRANS/HSIZE/HBURST/HRESP encodings, default register offsets, state enum.
REQ-025 SHALL be a single module with no sub-module; the transfer index SHALL be a 3-bit counter 0-4.

Verification
REQ-026 Zero-wait: opa=16'h0003, opb=16'h0004, mode=2'b00, slave model returns 32'h7 -> four writes then one read at 0x00/04/08/0C/10 on consecutive cycles, rsp_valid at edge 7, rsp_result=32'h7, rsp_error=0.
REQ-027 Wait states: slave inserts 2 wait cycles on the MODE write -> outputs stable during waits, rsp_valid at edge 9, result correct.
REQ-028 Error: slave answers ERROR on the OPB write -> htrans IDLE in the first error cycle, no MODE/CTRL/RES transfers, rsp_error=1, rsp_result=0.
REQ-029 Backpressure: rsp_ready held low for 5 cycles while cmd_valid=1 -> rsp stable, cmd_ready=0, the new command accepted only after rsp_ready.
REQ-030 Reset mid-sequence: hresetn low during the CTRL address phase -> the next cycle shows all reset values, no rsp_valid, and a new command runs cleanly.
